// File: rtl/screen_pkg.sv
// Shared constants and state encoding for the Z88 screen render stage.
package screen_pkg;

    localparam int unsigned LINE_PIX = 640;
    localparam int unsigned WPL      = LINE_PIX / 4;
    localparam int unsigned NLINES   = 64;

    localparam int unsigned ATTR_HRS = 13;
    localparam int unsigned ATTR_REV = 12;
    localparam int unsigned ATTR_FLS = 11;
    localparam int unsigned ATTR_GRY = 10;
    localparam int unsigned ATTR_UND = 9;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH
    } state_e;

endpackage

// File: rtl/screen_attr_decode.sv
// Applies attribute effects to one glyph row; output pixels are left-aligned.
module screen_attr_decode
    import screen_pkg::*;
(
    input  logic [13:0] attr_i,
    input  logic [7:0]  pix_i,
    input  logic [2:0]  row_i,
    input  logic [5:0]  line_i,
    input  logic [10:0] xpix_i,
    input  logic        flash_i,
    output logic [7:0]  pixels_o,
    output logic [3:0]  width_o
);

    logic        hrs;
    logic        is_null;
    logic [7:0]  px;
    logic [10:0] grey_base;

    always_comb begin
        hrs       = attr_i[ATTR_HRS];
        is_null   = hrs && attr_i[ATTR_REV] && attr_i[ATTR_FLS] && attr_i[ATTR_GRY];
        grey_base = xpix_i + 11'(line_i);

        px = hrs ? pix_i : {pix_i[5:0], 2'b00};
        if (attr_i[ATTR_UND] && !hrs && (row_i == 3'd7)) begin
            px = 8'hFC;
        end
        if (attr_i[ATTR_REV]) begin
            px = ~px;
        end
        if (attr_i[ATTR_FLS] && !flash_i) begin
            px = 8'h00;
        end
        // Even offsets (bits 7,5,3,1) follow the base parity, odd offsets the opposite.
        if (attr_i[ATTR_GRY]) begin
            px = px & (grey_base[0] ? 8'hAA : 8'h55);
        end

        if (is_null) begin
            pixels_o = 8'h00;
            width_o  = 4'd0;
        end else begin
            pixels_o = px & (hrs ? 8'hFF : 8'hFC);
            width_o  = hrs ? 4'd8 : 4'd6;
        end
    end

endmodule

// File: rtl/screen_render.sv
// Packs decoded character cells into 4-pixel VRAM words, one line at a time.
module screen_render
    import screen_pkg::*;
(
    input  logic        mck,
    input  logic        rin_n,
    input  logic        cell_vld,
    output logic        cell_rdy,
    input  logic [13:0] cell_attr,
    input  logic [7:0]  cell_pix,
    input  logic [5:0]  cell_line,
    input  logic        cell_last,
    input  logic        flash,
    output logic [13:0] vram_a,
    output logic [3:0]  vram_do,
    output logic        vram_we,
    output logic        line_done
);

    localparam logic [7:0]  WplXw = 8'(WPL);
    localparam logic [13:0] WplA  = 14'(WPL);

    state_e      state_q, state_d;
    logic [10:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  xw_q, xw_d;
    logic [10:0] xpix_q, xpix_d;
    logic [5:0]  line_q, line_d;
    logic        last_q, last_d;
    logic        rdy_q, rdy_d;
    logic        we_q, we_d;
    logic [13:0] a_q, a_d;
    logic [3:0]  do_q, do_d;
    logic        ld_q, ld_d;

    logic [7:0]  dec_pix;
    logic [3:0]  dec_width;
    logic        accept;
    logic        emit;
    logic [3:0]  emit_data;
    logic [13:0] addr;

    screen_attr_decode u_decode (
        .attr_i   (cell_attr),
        .pix_i    (cell_pix),
        .row_i    (cell_line[2:0]),
        .line_i   (cell_line),
        .xpix_i   (xpix_q),
        .flash_i  (flash),
        .pixels_o (dec_pix),
        .width_o  (dec_width)
    );

    assign accept = cell_vld && rdy_q;
    assign addr   = {8'd0, line_q} * WplA + {6'd0, xw_q};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        xw_d      = xw_q;
        xpix_d    = xpix_q;
        line_d    = line_q;
        last_d    = last_q;
        we_d      = 1'b0;
        a_d       = a_q;
        do_d      = do_q;
        ld_d      = 1'b0;
        emit      = 1'b0;
        emit_data = acc_q[10:7];

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // New pixels land directly behind the pending ones.
                    acc_d   = acc_q | ({dec_pix, 3'b000} >> cnt_q);
                    cnt_d   = cnt_q + dec_width;
                    xpix_d  = xpix_q + 11'(dec_width);
                    line_d  = cell_line;
                    last_d  = cell_last;
                    state_d = ((dec_width == 4'd0) && cell_last) ? FLUSH : DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q >= 4'd4) begin
                    emit  = 1'b1;
                    acc_d = acc_q << 4;
                    cnt_d = cnt_q - 4'd4;
                end
                if (cnt_d < 4'd4) begin
                    state_d = last_q ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                if (cnt_q != 4'd0) begin
                    emit  = 1'b1;
                    acc_d = '0;
                    cnt_d = '0;
                end else if (xw_q != WplXw) begin
                    emit      = 1'b1;
                    emit_data = 4'b0000;
                end else begin
                    ld_d    = 1'b1;
                    xw_d    = '0;
                    xpix_d  = '0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Words beyond the right edge still consume the accumulator but are not written.
        if (emit && (xw_q != WplXw)) begin
            we_d = 1'b1;
            a_d  = addr;
            do_d = emit_data;
            xw_d = xw_q + 8'd1;
        end

        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            xw_q    <= '0;
            xpix_q  <= '0;
            line_q  <= '0;
            last_q  <= 1'b0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            a_q     <= '0;
            do_q    <= '0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            xw_q    <= xw_d;
            xpix_q  <= xpix_d;
            line_q  <= line_d;
            last_q  <= last_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            a_q     <= a_d;
            do_q    <= do_d;
            ld_q    <= ld_d;
        end
    end

    assign cell_rdy  = rdy_q;
    assign vram_we   = we_q;
    assign vram_a    = a_q;
    assign vram_do   = do_q;
    assign line_done = ld_q;

endmodule

// File: tb/tb_screen_render.sv
// Directed bench for screen_render: single-cell vector table plus multi-cycle sequences.
module tb_screen_render;

    logic        mck;
    logic        rin_n;
    logic        cell_vld;
    logic        cell_rdy;
    logic [13:0] cell_attr;
    logic [7:0]  cell_pix;
    logic [5:0]  cell_line;
    logic        cell_last;
    logic        flash;
    logic [13:0] vram_a;
    logic [3:0]  vram_do;
    logic        vram_we;
    logic        line_done;

    int checks = 0;
    int errors = 0;

    logic [13:0] log_a[$];
    logic [3:0]  log_d[$];
    int          ld_cnt = 0;

    screen_render dut (
        .mck       (mck),
        .rin_n     (rin_n),
        .cell_vld  (cell_vld),
        .cell_rdy  (cell_rdy),
        .cell_attr (cell_attr),
        .cell_pix  (cell_pix),
        .cell_line (cell_line),
        .cell_last (cell_last),
        .flash     (flash),
        .vram_a    (vram_a),
        .vram_do   (vram_do),
        .vram_we   (vram_we),
        .line_done (line_done)
    );

    initial mck = 1'b0;
    always #5 mck = ~mck;

    always @(negedge mck) begin
        if (vram_we === 1'b1) begin
            log_a.push_back(vram_a);
            log_d.push_back(vram_do);
        end
        if (line_done === 1'b1) ld_cnt++;
    end

    typedef struct {
        logic [13:0] attr;
        logic [7:0]  pix;
        logic [5:0]  line;
        logic        fl;
        int          n;
        logic [3:0]  d0;
        logic [3:0]  d1;
        logic [13:0] a0;
        int          cyc;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rin_n    = 1'b0;
        cell_vld = 1'b0;
        repeat (2) @(posedge mck);
        #1 rin_n = 1'b1;
        @(posedge mck);
        #1;
    endtask

    // Presents a cell and returns just after the edge that accepted it.
    task automatic send_cell(input logic [13:0] attr, input logic [7:0] pix,
                             input logic [5:0] line, input logic last, input logic fl);
        int n;
        cell_attr = attr;
        cell_pix  = pix;
        cell_line = line;
        cell_last = last;
        flash     = fl;
        cell_vld  = 1'b1;
        n = 0;
        while (!cell_rdy && n < 400) begin
            @(posedge mck);
            #1;
            n++;
        end
        if (!cell_rdy) begin
            chk("send_timeout", 32'(cell_rdy), 32'd1);
            cell_vld = 1'b0;
        end else begin
            @(posedge mck);
            #1 cell_vld = 1'b0;
        end
    endtask

    task automatic wait_rdy(output int cyc);
        cyc = 0;
        do begin
            @(posedge mck);
            #1;
            cyc++;
        end while (!cell_rdy && cyc < 400);
        if (!cell_rdy) chk("rdy_timeout", 32'(cell_rdy), 32'd1);
    endtask

    task automatic wait_line_done(input int ld0);
        int n;
        n = 0;
        while (ld_cnt == ld0 && n < 1000) begin
            @(posedge mck);
            #1;
            n++;
        end
        if (ld_cnt == ld0) chk("line_done_timeout", 32'(ld_cnt - ld0), 32'd1);
        repeat (3) @(posedge mck);
        #1;
    endtask

    initial begin
        int base;
        int cyc;
        int got;
        int ld0;
        int bad;
        logic [13:0] amax;
        logic [13:0] amin;

        //              attr      pix    line fl  n  d0    d1    a0       cyc
        vecs[0]  = '{14'h2041, 8'hA5,  0, 1, 2, 4'hA, 4'h5, 14'd0,     2};
        vecs[1]  = '{14'h0000, 8'h2A,  1, 1, 1, 4'hA, 4'h0, 14'd160,   1};
        vecs[2]  = '{14'h1200, 8'h00,  7, 1, 1, 4'h0, 4'h0, 14'd1120,  1};
        vecs[3]  = '{14'h0200, 8'h00, 15, 1, 1, 4'hF, 4'h0, 14'd2400,  1};
        vecs[4]  = '{14'h0200, 8'h00,  6, 1, 1, 4'h0, 4'h0, 14'd960,   1};
        vecs[5]  = '{14'h0800, 8'h3F,  2, 0, 1, 4'h0, 4'h0, 14'd320,   1};
        vecs[6]  = '{14'h0800, 8'h3F,  2, 1, 1, 4'hF, 4'h0, 14'd320,   1};
        vecs[7]  = '{14'h3000, 8'h0F,  3, 1, 2, 4'hF, 4'h0, 14'd480,   2};
        vecs[8]  = '{14'h2400, 8'hFF,  0, 1, 2, 4'h5, 4'h5, 14'd0,     2};
        vecs[9]  = '{14'h2400, 8'hFF,  1, 1, 2, 4'hA, 4'hA, 14'd160,   2};
        vecs[10] = '{14'h3C00, 8'hFF,  0, 1, 0, 4'h0, 4'h0, 14'd0,     1};
        vecs[11] = '{14'h2200, 8'h00,  7, 1, 2, 4'h0, 4'h0, 14'd1120,  2};
        vecs[12] = '{14'h3800, 8'h0F,  0, 1, 2, 4'hF, 4'h0, 14'd0,     2};
        vecs[13] = '{14'h3800, 8'h0F,  0, 0, 2, 4'h0, 4'h0, 14'd0,     2};
        vecs[14] = '{14'h0000, 8'hC0,  1, 1, 1, 4'h0, 4'h0, 14'd160,   1};
        vecs[15] = '{14'h2000, 8'h3C, 63, 1, 2, 4'h3, 4'hC, 14'd10080, 2};

        rin_n     = 1'b0;
        cell_vld  = 1'b0;
        cell_attr = '0;
        cell_pix  = '0;
        cell_line = '0;
        cell_last = 1'b0;
        flash     = 1'b1;

        #12;
        chk("rst_rdy", 32'(cell_rdy), 32'd0);
        chk("rst_we", 32'(vram_we), 32'd0);
        chk("rst_a", 32'(vram_a), 32'd0);
        chk("rst_do", 32'(vram_do), 32'd0);
        chk("rst_ld", 32'(line_done), 32'd0);
        rin_n = 1'b1;
        #1 chk("rdy_before_edge", 32'(cell_rdy), 32'd0);
        @(posedge mck);
        #1 chk("rdy_after_edge", 32'(cell_rdy), 32'd1);

        for (int i = 0; i < 16; i++) begin
            do_reset();
            base = log_a.size();
            send_cell(vecs[i].attr, vecs[i].pix, vecs[i].line, 1'b0, vecs[i].fl);
            wait_rdy(cyc);
            repeat (3) @(posedge mck);
            #1;
            got = log_a.size() - base;
            chk($sformatf("v%0d_cyc", i), 32'(cyc), 32'(vecs[i].cyc));
            chk($sformatf("v%0d_nwr", i), 32'(got), 32'(vecs[i].n));
            if (vecs[i].n >= 1 && got >= 1) begin
                chk($sformatf("v%0d_d0", i), 32'(log_d[base]), 32'(vecs[i].d0));
                chk($sformatf("v%0d_a0", i), 32'(log_a[base]), 32'(vecs[i].a0));
            end
            if (vecs[i].n >= 2 && got >= 2) begin
                chk($sformatf("v%0d_d1", i), 32'(log_d[base+1]), 32'(vecs[i].d1));
                chk($sformatf("v%0d_a1", i), 32'(log_a[base+1]), 32'(vecs[i].a0 + 14'd1));
            end
        end

        // Two lores cells leave a 4-bit remainder that drains as a third word.
        do_reset();
        base = log_a.size();
        send_cell(14'h0000, 8'h3F, 6'd1, 1'b0, 1'b1);
        send_cell(14'h0000, 8'h00, 6'd1, 1'b0, 1'b1);
        wait_rdy(cyc);
        repeat (3) @(posedge mck);
        #1;
        chk("two_lores_nwr", 32'(log_a.size() - base), 32'd3);
        if (log_a.size() - base == 3) begin
            chk("two_lores_d0", 32'({log_a[base], log_d[base]}), 32'({14'd160, 4'hF}));
            chk("two_lores_d1", 32'({log_a[base+1], log_d[base+1]}), 32'({14'd161, 4'hC}));
            chk("two_lores_d2", 32'({log_a[base+2], log_d[base+2]}), 32'({14'd162, 4'h0}));
        end

        // Grey after a lores cell: xpix=6, line 0 -> mask 8'h55 behind pending 2'b11.
        do_reset();
        base = log_a.size();
        send_cell(14'h0000, 8'h3F, 6'd0, 1'b0, 1'b1);
        send_cell(14'h2400, 8'hFF, 6'd0, 1'b0, 1'b1);
        wait_rdy(cyc);
        repeat (3) @(posedge mck);
        #1;
        chk("grey_seq_nwr", 32'(log_a.size() - base), 32'd3);
        if (log_a.size() - base == 3) begin
            chk("grey_seq_w", 32'({log_d[base], log_d[base+1], log_d[base+2]}), 32'h0FD5);
        end

        // Last cell of a line flushes the remainder and zero-fills to the edge.
        do_reset();
        base = log_a.size();
        ld0  = ld_cnt;
        send_cell(14'h0000, 8'h3F, 6'd0, 1'b1, 1'b1);
        wait_line_done(ld0);
        chk("flush_nwr", 32'(log_a.size() - base), 32'd160);
        chk("flush_ld", 32'(ld_cnt - ld0), 32'd1);
        if (log_a.size() - base == 160) begin
            chk("flush_w0", 32'(log_d[base]), 32'hF);
            chk("flush_w1", 32'(log_d[base+1]), 32'hC);
            bad = 0;
            for (int k = 2; k < 160; k++) begin
                if (log_d[base+k] !== 4'h0 || log_a[base+k] !== 14'(k)) bad++;
            end
            chk("flush_fill", 32'(bad), 32'd0);
        end
        base = log_a.size();
        send_cell(14'h2041, 8'hA5, 6'd0, 1'b0, 1'b1);
        wait_rdy(cyc);
        repeat (3) @(posedge mck);
        #1;
        chk("xw_restart_nwr", 32'(log_a.size() - base), 32'd2);
        if (log_a.size() - base >= 1) begin
            chk("xw_restart_a", 32'({log_a[base], log_d[base]}), 32'({14'd0, 4'hA}));
        end

        // 880 pixels on one line: only the first 640 reach VRAM.
        do_reset();
        base = log_a.size();
        ld0  = ld_cnt;
        for (int c = 0; c < 110; c++) begin
            send_cell(14'h2000, 8'hFF, 6'd5, (c == 109), 1'b1);
        end
        wait_line_done(ld0);
        chk("clip_nwr", 32'(log_a.size() - base), 32'd160);
        chk("clip_ld", 32'(ld_cnt - ld0), 32'd1);
        amax = '0;
        amin = '1;
        bad  = 0;
        for (int k = base; k < log_a.size(); k++) begin
            if (log_a[k] > amax) amax = log_a[k];
            if (log_a[k] < amin) amin = log_a[k];
            if (log_d[k] !== 4'hF) bad++;
        end
        chk("clip_amax", 32'(amax), 32'd959);
        chk("clip_amin", 32'(amin), 32'd800);
        chk("clip_data", 32'(bad), 32'd0);

        // Reset while draining kills the write strobe at once and abandons the line.
        do_reset();
        send_cell(14'h2041, 8'hA5, 6'd0, 1'b0, 1'b1);
        @(posedge mck);
        #1 chk("mid_rst_pre_we", 32'(vram_we), 32'd1);
        #2 rin_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(vram_we), 32'd0);
        chk("mid_rst_rdy", 32'(cell_rdy), 32'd0);
        base = log_a.size();
        repeat (2) @(posedge mck);
        #1 rin_n = 1'b1;
        repeat (6) @(posedge mck);
        #1;
        chk("mid_rst_nwr", 32'(log_a.size() - base), 32'd0);
        chk("mid_rst_idle", 32'(cell_rdy), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
